// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator.
//   pc_state_t : front-end FSM states (BOOT, RUN, HALT)
//   DEF_*      : default PC width, step, vectors and counter width
//   align_lsb  : number of PC low bits forced to zero by alignment
// Optional feature macro: PC_TRAP_EN (trap constants are used only then).
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int          DEF_XLEN      = 32;
    localparam int          DEF_STEP      = 4;
    localparam int          DEF_CNT_W     = 16;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0004;

    // ALIGN_LSB helper: STEP is a power of two, so its log2 is the count
    // of address bits that must be zero in every fetched PC.
    function automatic int align_lsb(input int step);
        return $clog2(step);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
//   cur_pc         in  : PC currently presented on the request port
//   redirect_valid in  : load redirect_pc (already gated by the caller)
//   redirect_pc    in  : redirect target, possibly misaligned
//   advance        in  : a request fired and the pipeline is not stalled
//   trap_valid     in  : take trap (PC_TRAP_EN builds only)
//   next_pc        out : PC for the next cycle
//   misalign       out : a taken redirect had nonzero low alignment bits
// Priority, highest first: trap (PC_TRAP_EN) > redirect > advance > hold.
// Optional feature macro: PC_TRAP_EN.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int STEP = DEF_STEP
`ifdef PC_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
`endif
) (
    input  logic [XLEN-1:0] cur_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
`ifdef PC_TRAP_EN
    input  logic            trap_valid,
`endif
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    localparam int ALIGN_LSB = align_lsb(STEP);
    // Ones in the low ALIGN_LSB bits; all zero when STEP is 1.
    localparam logic [XLEN-1:0] LOW_MASK = {XLEN{1'b1}} >> (XLEN - ALIGN_LSB);

    always_comb begin
        next_pc  = cur_pc;
        misalign = 1'b0;
        if (redirect_valid) begin
            next_pc  = redirect_pc & ~LOW_MASK;
            misalign = |(redirect_pc & LOW_MASK);
        end else if (advance) begin
            // Wraps modulo 2^XLEN with no flag.
            next_pc = cur_pc + XLEN'(STEP);
        end
`ifdef PC_TRAP_EN
        // Assigned last so a trap overrides a simultaneous redirect.
        if (trap_valid) begin
            next_pc  = TRAP_VEC;
            misalign = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch front end.
//   clk, rst (async, active-low)
//   en             in  : global run enable
//   stall          in  : blocks sequential advance (fired requests still count)
//   redirect_valid in  : load redirect_pc (low alignment bits cleared)
//   redirect_pc    in  : redirect target
//   req_ready      in  : fetch side accepts the request
//   trap_valid     in  : take trap (PC_TRAP_EN only)
//   epc            out : PC captured at trap (PC_TRAP_EN only)
//   req_valid      out : fetch request valid
//   req_pc         out : fetch request address
//   ce             out : front end active (set when leaving BOOT)
//   misalign       out : one-cycle pulse after a misaligned redirect
//   req_cnt        out : accepted-request count, wraps
//   fsm_state      out : current FSM state, for observation
// Handshake: a request fires when req_valid & req_ready on a rising edge;
// while req_valid & !req_ready, req_pc holds unless a redirect or trap
// replaces the pending request. All outputs are registered.
// Optional feature macro: PC_TRAP_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter int              STEP      = DEF_STEP,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter int              CNT_W     = DEF_CNT_W
`ifdef PC_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             req_ready,
`ifdef PC_TRAP_EN
    input  logic             trap_valid,
    output logic [XLEN-1:0]  epc,
`endif
    output logic             req_valid,
    output logic [XLEN-1:0]  req_pc,
    output logic             ce,
    output logic             misalign,
    output logic [CNT_W-1:0] req_cnt,
    output pc_state_t        fsm_state
);

    pc_state_t        state, state_d;
    logic             valid_d, ce_d;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0]  sel_pc;
    logic             sel_mis;
    logic             fire, active;

    assign fire      = req_valid & req_ready;
    // Redirects and traps are ignored in BOOT so the first fetch is
    // always the reset vector.
    assign active    = (state != BOOT);
    assign fsm_state = state;

    pc_next_sel #(
        .XLEN     (XLEN),
        .STEP     (STEP)
`ifdef PC_TRAP_EN
        ,
        .TRAP_VEC (TRAP_VEC)
`endif
    ) u_next_sel (
        .cur_pc         (req_pc),
        .redirect_valid (redirect_valid & active),
        .redirect_pc    (redirect_pc),
        .advance        (fire & ~stall),
`ifdef PC_TRAP_EN
        .trap_valid     (trap_valid & active),
`endif
        .next_pc        (sel_pc),
        .misalign       (sel_mis)
    );

    always_comb begin
        state_d = state;
        valid_d = req_valid;
        ce_d    = ce;
        cnt_d   = fire ? req_cnt + CNT_W'(1) : req_cnt;
        case (state)
            BOOT: begin
                if (en) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    ce_d    = 1'b1;
                end
            end
            RUN: begin
                // req_valid is always high in RUN, so with en low the
                // only way out is the fire of the pending request.
                if (!en && fire) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end
            end
            HALT: begin
                if (en) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            req_pc    <= RESET_VEC;
            req_valid <= 1'b0;
            ce        <= 1'b0;
            misalign  <= 1'b0;
            req_cnt   <= '0;
        end else begin
            state     <= state_d;
            req_pc    <= sel_pc;
            req_valid <= valid_d;
            ce        <= ce_d;
            misalign  <= sel_mis;
            req_cnt   <= cnt_d;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc <= '0;
        end else if (trap_valid && active) begin
            epc <= req_pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen (default parameters).
// Each cycle the driver sets inputs on the falling edge, a reference model
// pushes the expected next-cycle outputs to exp_q, and the outputs are
// popped and compared 1 time unit after the rising edge.
// Optional feature macro: PC_TRAP_EN (adds trap stimulus and epc checks).
module tb_pc_gen;
    import pc_pkg::*;

    localparam int EXP_W = 32 + 2 + 1 + 1 + 1 + 16 + 32;
    localparam logic [31:0] TRAP_PC = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, stall, redirect_valid, req_ready, trap_valid;
    logic [31:0] redirect_pc;
    logic        req_valid, ce, misalign;
    logic [31:0] req_pc;
    logic [15:0] req_cnt;
    pc_state_t   fsm_state;
`ifdef PC_TRAP_EN
    logic [31:0] epc;
`endif

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_ready      (req_ready),
`ifdef PC_TRAP_EN
        .trap_valid     (trap_valid),
        .epc            (epc),
`endif
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .ce             (ce),
        .misalign       (misalign),
        .req_cnt        (req_cnt),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_state;
    logic        m_valid, m_ce, m_mis;
    logic [31:0] m_pc, m_epc;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_state = 2'd0; m_valid = 1'b0; m_ce = 1'b0; m_mis = 1'b0;
        m_pc = 32'h0; m_cnt = 16'h0; m_epc = 32'h0;
    endtask

    // Expected outputs after the coming rising edge, from model + inputs.
    function automatic logic [EXP_W-1:0] model_next();
        logic [1:0]  s;
        logic        v, c, mis, fire;
        logic [31:0] pc, e;
        logic [15:0] cnt;
        s = m_state; v = m_valid; c = m_ce; mis = 1'b0;
        pc = m_pc; e = m_epc; cnt = m_cnt;
        fire = m_valid && req_ready;
        if (m_state == 2'd0) begin
            if (en) begin s = 2'd1; v = 1'b1; c = 1'b1; end
        end else begin
            if (fire) cnt = m_cnt + 16'd1;
            if (trap_valid) begin
                pc = TRAP_PC; e = m_pc;
            end else if (redirect_valid) begin
                pc = {redirect_pc[31:2], 2'b00};
                mis = (redirect_pc[1:0] != 2'b00);
            end else if (fire && !stall) begin
                pc = m_pc + 32'd4;
            end
            if (m_state == 2'd1 && !en && fire) begin s = 2'd2; v = 1'b0; end
            if (m_state == 2'd2 && en) begin s = 2'd1; v = 1'b1; end
        end
        return {e, s, v, c, mis, cnt, pc};
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input logic e, input logic s, input logic rv,
                       input logic [31:0] rp, input logic r, input logic t);
        logic [EXP_W-1:0] x;
        en = e; stall = s; redirect_valid = rv; redirect_pc = rp; req_ready = r;
`ifdef PC_TRAP_EN
        trap_valid = t;
`else
        trap_valid = 1'b0 & t;
`endif
        exp_q.push_back(model_next());
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check("req_pc",    req_pc,           x[31:0]);
        check("req_cnt",   32'(req_cnt),     32'(x[47:32]));
        check("misalign",  32'(misalign),    32'(x[48]));
        check("ce",        32'(ce),          32'(x[49]));
        check("req_valid", 32'(req_valid),   32'(x[50]));
        check("state",     32'(fsm_state),   32'(x[52:51]));
`ifdef PC_TRAP_EN
        check("epc",       epc,              x[84:53]);
`endif
        {m_epc, m_state, m_valid, m_ce, m_mis, m_cnt, m_pc} = x;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    req_pc,             32'h0);
        check({tag, "_valid"}, 32'(req_valid),     32'h0);
        check({tag, "_ce"},    32'(ce),            32'h0);
        check({tag, "_mis"},   32'(misalign),      32'h0);
        check({tag, "_cnt"},   32'(req_cnt),       32'h0);
        check({tag, "_state"}, 32'(fsm_state),     32'(BOOT));
`ifdef PC_TRAP_EN
        check({tag, "_epc"},   epc,                32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        req_ready = 1'b0; trap_valid = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst0");
        @(negedge clk);
        rst = 1'b1;

        // Boot and full-rate fetch: 0, 4, 8.
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("boot_pc", req_pc, 32'h0);
        check("boot_ce", 32'(ce), 32'h1);
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        // Fetch side not ready for three cycles at PC 8.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 0, 0);
        check("hold_pc", req_pc, 32'h8);
        check("hold_cnt", 32'(req_cnt), 32'd2);
        check("hold_valid", 32'(req_valid), 32'h1);
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("seq_pc", req_pc, 32'h10);
        check("seq_cnt", 32'(req_cnt), 32'd4);

        // Misaligned redirect replacing an unaccepted request.
        cyc(1, 0, 1, 32'h103, 0, 0);
        check("redir_pc", req_pc, 32'h100);
        check("redir_mis", 32'(misalign), 32'h1);
        cyc(1, 0, 0, 32'h0, 0, 0);
        check("mis_pulse_end", 32'(misalign), 32'h0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("redir_seq", req_pc, 32'h104);

        // Stall with ready high: same PC re-requested, count keeps going.
        cyc(1, 0, 1, 32'h20, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0, 1, 0);
        check("stall_pc", req_pc, 32'h20);
        check("stall_cnt", 32'(req_cnt), 32'd8);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("stall_release", req_pc, 32'h24);

        // PC wrap at the top of the address space.
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("wrap_pc", req_pc, 32'h0);

        // Redirect coinciding with a fire: old PC counts, new PC loads.
        cyc(1, 0, 1, 32'h200, 1, 0);
        check("redir_fire_cnt", 32'(req_cnt), 32'd11);

        // Drop en with a pending request: stay in RUN until it fires.
        cyc(0, 0, 0, 32'h0, 0, 0);
        cyc(0, 0, 0, 32'h0, 0, 0);
        check("en_drop_valid", 32'(req_valid), 32'h1);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check("halt_valid", 32'(req_valid), 32'h0);
        check("halt_state", 32'(fsm_state), 32'(HALT));
        check("halt_ce", 32'(ce), 32'h1);
        cyc(0, 0, 1, 32'h300, 1, 0);
        check("halt_redir", req_pc, 32'h300);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("resume_valid", 32'(req_valid), 32'h1);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("resume_seq", req_pc, 32'h304);

`ifdef PC_TRAP_EN
        // Trap beats a simultaneous redirect.
        cyc(1, 0, 1, 32'h40, 0, 0);
        cyc(1, 0, 1, 32'h80, 1, 1);
        check("trap_pc", req_pc, TRAP_PC);
        check("trap_epc", epc, 32'h40);
`endif

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            cyc(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 5) == 0), $urandom,
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0));
        end

        // Make sure the front end is running, then reset mid-cycle.
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(1, 0, 1, 32'h500, 0, 0);
        #2 rst = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 32'h0, 1, 0);
        cyc(0, 0, 0, 32'h0, 1, 0);
        check("boot_wait_valid", 32'(req_valid), 32'h0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        cyc(1, 0, 0, 32'h0, 1, 0);
        check("reboot_pc", req_pc, 32'h4);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
